// File: rtl/double_to_long_small.sv
// Iterative IEEE-754 double to signed 64-bit integer converter: one bit of alignment per clock.
// Define DOUBLE_TO_LONG_ROUND_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module double_to_long_small (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] double_val,
  input  logic        double_cont,
  output logic        double_ready,
  output logic [63:0] long_val,
  output logic        long_ready,
  input  logic        long_cont
);

  typedef enum logic [2:0] {
    GETIN,
    UNPACK,
    SHIFT,
    ROUND,
    SIGN,
    PUTOUT
  } state_t;

  state_t      state, state_n;
  logic [63:0] operand, operand_n;
  logic        sign, sign_n;
  logic [63:0] value, value_n;
  logic [6:0]  cnt, cnt_n;
  logic [63:0] z, z_n;
  logic [63:0] long_val_n;
  logic        long_ready_n;
  logic        double_ready_n;

  logic        exp_nan;
  logic        exp_sat;
  logic        exp_zero;
  logic [10:0] exp_field;
  logic [51:0] frac;

`ifdef DOUBLE_TO_LONG_ROUND_EN
  logic        r, r_n;
  logic        st, st_n;
  logic        round_up;
`endif

  assign exp_field = operand[62:52];
  assign frac      = operand[51:0];
  assign exp_nan   = (exp_field == 11'd2047) && (frac != 52'd0);
  // Infinity lands here too: its exponent field (2047) is above the e=63 threshold of 1086.
  assign exp_sat   = (exp_field >= 11'd1086);
`ifdef DOUBLE_TO_LONG_ROUND_EN
  // e=-1 still reaches the shifter so that values in [0.5,1) can round up to 1.
  assign exp_zero  = (exp_field < 11'd1022);
  assign round_up  = r && (st || value[0]);
`else
  assign exp_zero  = (exp_field < 11'd1023);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GETIN;
      operand      <= '0;
      sign         <= 1'b0;
      value        <= '0;
      cnt          <= '0;
      z            <= '0;
      long_val     <= '0;
      long_ready   <= 1'b0;
      double_ready <= 1'b0;
`ifdef DOUBLE_TO_LONG_ROUND_EN
      r            <= 1'b0;
      st           <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      operand      <= operand_n;
      sign         <= sign_n;
      value        <= value_n;
      cnt          <= cnt_n;
      z            <= z_n;
      long_val     <= long_val_n;
      long_ready   <= long_ready_n;
      double_ready <= double_ready_n;
`ifdef DOUBLE_TO_LONG_ROUND_EN
      r            <= r_n;
      st           <= st_n;
`endif
    end
  end

  always_comb begin
    state_n        = state;
    operand_n      = operand;
    sign_n         = sign;
    value_n        = value;
    cnt_n          = cnt;
    z_n            = z;
    long_val_n     = long_val;
    long_ready_n   = long_ready;
    double_ready_n = double_ready;
`ifdef DOUBLE_TO_LONG_ROUND_EN
    r_n            = r;
    st_n           = st;
`endif

    case (state)
      GETIN: begin
        double_ready_n = 1'b1;
        if (double_ready && double_cont) begin
          operand_n      = double_val;
          double_ready_n = 1'b0;
          state_n        = UNPACK;
        end
      end

      UNPACK: begin
        sign_n = operand[63];
        if (exp_nan) begin
          z_n     = 64'd0;
          state_n = PUTOUT;
        end else if (exp_sat) begin
          z_n     = operand[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
          state_n = PUTOUT;
        end else if (exp_zero) begin
          z_n     = 64'd0;
          state_n = PUTOUT;
        end else begin
          value_n = {1'b1, frac, 11'd0};
          // Shift count is 63-e, i.e. 1086 minus the biased exponent.
          cnt_n   = 7'(11'd1086 - exp_field);
`ifdef DOUBLE_TO_LONG_ROUND_EN
          r_n     = 1'b0;
          st_n    = 1'b0;
`endif
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt != 7'd0) begin
`ifdef DOUBLE_TO_LONG_ROUND_EN
          st_n = st | r;
          r_n  = value[0];
`endif
          value_n = value >> 1;
          cnt_n   = cnt - 7'd1;
        end else begin
          state_n = ROUND;
        end
      end

      ROUND: begin
`ifdef DOUBLE_TO_LONG_ROUND_EN
        value_n = value + {63'd0, round_up};
`endif
        state_n = SIGN;
      end

      SIGN: begin
        z_n     = sign ? (64'd0 - value) : value;
        state_n = PUTOUT;
      end

      PUTOUT: begin
        long_val_n   = z;
        long_ready_n = 1'b1;
        if (long_ready && long_cont) begin
          long_ready_n = 1'b0;
          state_n      = GETIN;
        end
      end

      default: begin
        state_n = GETIN;
      end
    endcase
  end

endmodule
